dp_sequencer: RTL and testbench

- Multi-cycle control FSM that sits directly upstream of the datapath.
- Replaces the manual switch-driven control interface with instruction-driven control.
- Accepts one 16-bit instruction per start/ready handshake and decodes it.
- Sequences the datapath control signals over several cycles (register read, execute, writeback), then pulses done.

---
 rtl/seq_pkg.sv | 42 ++++
 rtl/dp_sequencer_if.sv | 37 +++
 rtl/seq_decode.sv | 39 +++
 rtl/dp_sequencer.sv | 115 +++++++++++
 tb/tb_dp_sequencer.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared types and encodings for the datapath sequencer.
package seq_pkg;
    localparam int IW = 16;
    localparam int DW = 16;

    typedef enum logic [2:0] {
        IDLE, WIMM, GETA, GETB, EXEC, WREG, DONE
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    typedef enum logic [2:0] {
        C_MOVI, C_MOVR, C_ADD, C_CMP, C_AND, C_MVN, C_ILL
    } iclass_t;

    // Decoded view of one instruction; this is what the FSM latches.
    typedef struct packed {
        iclass_t       cls;
        logic [2:0]    rn;
        logic [2:0]    rd;
        logic [2:0]    rm;
        logic [1:0]    sh;
        logic [DW-1:0] sximm;
    } dec_t;

    function automatic logic [DW-1:0] sx8(input logic [7:0] v);
        return {{(DW-8){v[7]}}, v};
    endfunction
endpackage

// File: rtl/dp_sequencer_if.sv
// dp_sequencer_if: instruction handshake plus datapath control bundle.
interface dp_sequencer_if;
    import seq_pkg::*;

    logic          start;
    logic [IW-1:0] instr;
    logic          ready;
    logic          done;
    logic          illegal;
    logic [2:0]    readnum;
    logic [2:0]    writenum;
    logic          write;
    logic          vsel;
    logic          loada;
    logic          loadb;
    logic          asel;
    logic          bsel;
    logic [1:0]    shift;
    logic [1:0]    ALUop;
    logic          loadc;
    logic          loads;
    logic [DW-1:0] datapath_in;

    modport master (
        output start, instr,
        input  ready, done, illegal, readnum, writenum, write, vsel,
               loada, loadb, asel, bsel, shift, ALUop, loadc, loads,
               datapath_in
    );

    modport slave (
        input  start, instr,
        output ready, done, illegal, readnum, writenum, write, vsel,
               loada, loadb, asel, bsel, shift, ALUop, loadc, loads,
               datapath_in
    );
endinterface

// File: rtl/seq_decode.sv
// seq_decode: combinational instruction decode into class and fields.
// SEQ_SHIFT_EN: when defined, sh is passed through; otherwise it decodes as 00.
module seq_decode
    import seq_pkg::*;
(
    input  logic [IW-1:0] instr_i,
    output dec_t          dec_o
);
    logic [2:0] opc;
    logic [1:0] op;

    assign opc = instr_i[15:13];
    assign op  = instr_i[12:11];

    // Classify opcode/op pairs; anything not listed is illegal.
    always_comb begin
        dec_o.cls = C_ILL;
        if (opc == OPC_MOV) begin
            if (op == OP_MOVI)      dec_o.cls = C_MOVI;
            else if (op == OP_MOVR) dec_o.cls = C_MOVR;
        end else if (opc == OPC_ALU) begin
            case (op)
                OP_ADD:  dec_o.cls = C_ADD;
                OP_CMP:  dec_o.cls = C_CMP;
                OP_AND:  dec_o.cls = C_AND;
                default: dec_o.cls = C_MVN;
            endcase
        end
        dec_o.rn    = instr_i[10:8];
        dec_o.rd    = instr_i[7:5];
        dec_o.rm    = instr_i[2:0];
`ifdef SEQ_SHIFT_EN
        dec_o.sh    = instr_i[4:3];
`else
        dec_o.sh    = 2'b00;
`endif
        dec_o.sximm = sx8(instr_i[7:0]);
    end
endmodule

// File: rtl/dp_sequencer.sv
// dp_sequencer: instruction-driven multi-cycle control FSM for the datapath.
// Accepts one instruction per start/ready handshake and walks it through
// read / execute / writeback, then pulses done (with illegal on bad opcodes).
// SEQ_SHIFT_EN: enables the EXEC shift field (see seq_decode).
module dp_sequencer
    import seq_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    dp_sequencer_if.slave bus
);
    state_t state_q, state_d;
    dec_t   dec_in, dec_q, dec_d;

    seq_decode u_dec (
        .instr_i (bus.instr),
        .dec_o   (dec_in)
    );

    // Next-state and instruction latch; only IDLE captures a new instruction.
    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dec_d = dec_in;
                    case (dec_in.cls)
                        C_MOVI:               state_d = WIMM;
                        C_MOVR, C_MVN:        state_d = GETB;
                        C_ADD, C_CMP, C_AND:  state_d = GETA;
                        default:              state_d = DONE;
                    endcase
                end
            end
            WIMM:    state_d = DONE;
            GETA:    state_d = GETB;
            GETB:    state_d = EXEC;
            EXEC:    state_d = (dec_q.cls == C_CMP) ? DONE : WREG;
            WREG:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and latched-instruction registers; reset discards any partial op.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dec_q   <= '0;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
        end
    end

    // Moore control decode from state and latched fields; unlisted controls stay 0.
    always_comb begin
        bus.ready    = 1'b0;
        bus.done     = 1'b0;
        bus.illegal  = 1'b0;
        bus.readnum  = 3'd0;
        bus.writenum = 3'd0;
        bus.write    = 1'b0;
        bus.vsel     = 1'b0;
        bus.loada    = 1'b0;
        bus.loadb    = 1'b0;
        bus.asel     = 1'b0;
        bus.bsel     = 1'b0;
        bus.shift    = 2'b00;
        bus.ALUop    = ALU_ADD;
        bus.loadc    = 1'b0;
        bus.loads    = 1'b0;
        case (state_q)
            IDLE: bus.ready = 1'b1;
            WIMM: begin
                bus.writenum = dec_q.rn;
                bus.vsel     = 1'b1;
                bus.write    = 1'b1;
            end
            GETA: begin
                bus.readnum = dec_q.rn;
                bus.loada   = 1'b1;
            end
            GETB: begin
                bus.readnum = dec_q.rm;
                bus.loadb   = 1'b1;
            end
            EXEC: begin
                bus.shift = dec_q.sh;
                case (dec_q.cls)
                    C_CMP:   bus.ALUop = ALU_SUB;
                    C_AND:   bus.ALUop = ALU_AND;
                    C_MVN:   bus.ALUop = ALU_NOTB;
                    default: bus.ALUop = ALU_ADD;
                endcase
                // MOV-reg passes B through the adder with A zeroed.
                bus.asel  = (dec_q.cls == C_MOVR);
                bus.loads = (dec_q.cls == C_CMP);
                bus.loadc = (dec_q.cls != C_CMP);
            end
            WREG: begin
                bus.writenum = dec_q.rd;
                bus.write    = 1'b1;
            end
            DONE: begin
                bus.done    = 1'b1;
                bus.illegal = (dec_q.cls == C_ILL);
            end
            default: ;
        endcase
    end

    assign bus.datapath_in = dec_q.sximm;
endmodule

// File: tb/tb_dp_sequencer.sv
// tb_dp_sequencer: directed self-checking bench for dp_sequencer.
module tb_dp_sequencer;
    logic clk;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

`ifdef SEQ_SHIFT_EN
    localparam logic [1:0] ADD_SH = 2'b01;
`else
    localparam logic [1:0] ADD_SH = 2'b00;
`endif

    dp_sequencer_if bus ();

    dp_sequencer u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl vector: {done,illegal,write,vsel,loada,loadb,asel,bsel,loadc,loads,readnum,writenum,shift,ALUop}
    logic [19:0] ctl;
    assign ctl = {bus.done, bus.illegal, bus.write, bus.vsel, bus.loada,
                  bus.loadb, bus.asel, bus.bsel, bus.loadc, bus.loads,
                  bus.readnum, bus.writenum, bus.shift, bus.ALUop};

    function automatic logic [19:0] E(input logic [9:0] b, input logic [2:0] rn,
                                      input logic [2:0] wn, input logic [1:0] sh,
                                      input logic [1:0] alu);
        return {b, rn, wn, sh, alu};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic rdy, input logic [19:0] e);
        chk({tag, "_ready"}, {31'd0, bus.ready}, {31'd0, rdy});
        chk({tag, "_ctl"}, {12'd0, ctl}, {12'd0, e});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.instr = 16'h0000;
        step();
        step();
        chk_st("rst", 1'b1, 20'd0);
        chk("rst_dpin", {16'd0, bus.datapath_in}, 32'd0);
        reset_n = 1'b1;
        step();
        chk_st("idle", 1'b1, 20'd0);

        // MOV R3,#-2
        bus.start = 1'b1; bus.instr = 16'hD3FE;
        step(); bus.start = 1'b0; bus.instr = 16'h1234;
        chk_st("movi_c1", 1'b0, E(10'h0C0, 3'd0, 3'd3, 2'b00, 2'b00));
        chk("movi_dpin", {16'd0, bus.datapath_in}, 32'h0000FFFE);
        step();
        chk_st("movi_c2", 1'b0, E(10'h200, 3'd0, 3'd0, 2'b00, 2'b00));
        step();
        chk_st("movi_c3", 1'b1, 20'd0);
        chk("movi_hold", {16'd0, bus.datapath_in}, 32'h0000FFFE);

        // ADD R2,R1,R0 LSL
        bus.start = 1'b1; bus.instr = 16'hA148;
        step(); bus.start = 1'b0;
        chk_st("add_geta", 1'b0, E(10'h020, 3'd1, 3'd0, 2'b00, 2'b00));
        chk("add_dpin", {16'd0, bus.datapath_in}, 32'h00000048);
        step();
        chk_st("add_getb", 1'b0, E(10'h010, 3'd0, 3'd0, 2'b00, 2'b00));
        step();
        chk_st("add_exec", 1'b0, E(10'h002, 3'd0, 3'd0, ADD_SH, 2'b00));
        step();
        chk_st("add_wreg", 1'b0, E(10'h080, 3'd0, 3'd2, 2'b00, 2'b00));
        step();
        chk_st("add_done", 1'b0, E(10'h200, 3'd0, 3'd0, 2'b00, 2'b00));
        step();
        chk_st("add_idle", 1'b1, 20'd0);

        // CMP R1,R2: status only, no writeback
        bus.start = 1'b1; bus.instr = 16'hA902;
        step(); bus.start = 1'b0;
        chk_st("cmp_geta", 1'b0, E(10'h020, 3'd1, 3'd0, 2'b00, 2'b00));
        step();
        chk_st("cmp_getb", 1'b0, E(10'h010, 3'd2, 3'd0, 2'b00, 2'b00));
        step();
        chk_st("cmp_exec", 1'b0, E(10'h001, 3'd0, 3'd0, 2'b00, 2'b01));
        step();
        chk_st("cmp_done", 1'b0, E(10'h200, 3'd0, 3'd0, 2'b00, 2'b00));
        step();
        chk_st("cmp_idle", 1'b1, 20'd0);

        // MOV R5,R1 (reg): asel path
        bus.start = 1'b1; bus.instr = 16'hC0A1;
        step(); bus.start = 1'b0;
        chk_st("movr_getb", 1'b0, E(10'h010, 3'd1, 3'd0, 2'b00, 2'b00));
        step();
        chk_st("movr_exec", 1'b0, E(10'h00A, 3'd0, 3'd0, 2'b00, 2'b00));
        step();
        chk_st("movr_wreg", 1'b0, E(10'h080, 3'd0, 3'd5, 2'b00, 2'b00));
        step();
        chk_st("movr_done", 1'b0, E(10'h200, 3'd0, 3'd0, 2'b00, 2'b00));
        step();

        // MVN R3,R2
        bus.start = 1'b1; bus.instr = 16'hB862;
        step(); bus.start = 1'b0;
        chk_st("mvn_getb", 1'b0, E(10'h010, 3'd2, 3'd0, 2'b00, 2'b00));
        step();
        chk_st("mvn_exec", 1'b0, E(10'h002, 3'd0, 3'd0, 2'b00, 2'b11));
        step();
        chk_st("mvn_wreg", 1'b0, E(10'h080, 3'd0, 3'd3, 2'b00, 2'b00));
        step();
        chk_st("mvn_done", 1'b0, E(10'h200, 3'd0, 3'd0, 2'b00, 2'b00));
        step();

        // Illegal 0000, start held high through busy cycle
        bus.start = 1'b1; bus.instr = 16'h0000;
        step(); bus.instr = 16'hD3FE;
        chk_st("ill_done", 1'b0, E(10'h300, 3'd0, 3'd0, 2'b00, 2'b00));
        step();
        chk_st("ill_idle", 1'b1, 20'd0);
        chk("ill_dpin", {16'd0, bus.datapath_in}, 32'd0);
        step(); bus.start = 1'b0; bus.instr = 16'hFFFF;
        chk_st("held_wimm", 1'b0, E(10'h0C0, 3'd0, 3'd3, 2'b00, 2'b00));
        chk("held_dpin", {16'd0, bus.datapath_in}, 32'h0000FFFE);
        step();
        chk_st("held_done", 1'b0, E(10'h200, 3'd0, 3'd0, 2'b00, 2'b00));
        step();

        // Reset during EXEC of ADD
        bus.start = 1'b1; bus.instr = 16'hA148;
        step(); bus.start = 1'b0;
        step();
        step();
        chk_st("mid_exec", 1'b0, E(10'h002, 3'd0, 3'd0, ADD_SH, 2'b00));
        reset_n = 1'b0;
        #1;
        chk_st("mid_rst", 1'b1, 20'd0);
        chk("mid_dpin", {16'd0, bus.datapath_in}, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        chk_st("mid_after1", 1'b1, 20'd0);
        step();
        chk_st("mid_after2", 1'b1, 20'd0);

        // MOV-imm after reset completes normally
        bus.start = 1'b1; bus.instr = 16'hD3FE;
        step(); bus.start = 1'b0;
        chk_st("post_wimm", 1'b0, E(10'h0C0, 3'd0, 3'd3, 2'b00, 2'b00));
        step();
        chk_st("post_done", 1'b0, E(10'h200, 3'd0, 3'd0, 2'b00, 2'b00));
        step();
        chk_st("post_idle", 1'b1, 20'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
